timer_cascade_sequencer: RTL and testbench
==========================================

// Module: timer_cascade_sequencer
// PURPOSE
//  Countdown sequencer for the irrigation timer: loads a BCD duration MM:SS, divides clk to a 1 s tick,
//  and decrements a cascade of nine-to-zero digit stages (sec tens limited to 5-to-0) with borrow.
//  Sits between the irrigation control FSM (start/abort/pause) and the display/valve logic (bcd_out, done).
//  Digit stages are internal registers; all state changes happen on the clk rising edge.
// PARAMETERS
//  TICK_DIV   50_000_000   clk cycles per countdown tick; legal range 2 or more
//  CNT_W      26           prescaler width; must satisfy 2**CNT_W >= TICK_DIV
// PORTS
//  clk       in   1   system clock, rising edge
//  reset     in   1   synchronous, active-high reset
//  start     in   1   1-cycle pulse: load load_bcd and run
//  pause     in   1   level: while 1 in RUN/PAUSE, countdown frozen
//  abort     in   1   1-cycle pulse: cancel and clear, no done
//  load_bcd  in   16  {min_tens, min_units, sec_tens, sec_units} BCD
//  bcd_out   out  16  current remaining time, same packing as load_bcd
//  running   out  1   1 while in RUN
//  busy      out  1   1 while in RUN or PAUSE
//  sec_tick  out  1   1-cycle pulse on every applied decrement
//  done      out  1   1-cycle pulse when count reaches 00:00
// BEHAVIOUR
//  - Reset: state IDLE, bcd_out=16'h0000, prescaler=0, running=busy=sec_tick=done=0.
//  - States IDLE, RUN, PAUSE, DONE. Priority per cycle: reset > abort > start > pause > tick.
//  - Load clamping: digit >9 loads 9; sec_tens >5 loads 5. Clamped value appears on bcd_out.
//  - start (any state): load clamped load_bcd, prescaler:=0, next state RUN; bcd_out valid next cycle.
//    If the clamped load is 0000: next state DONE instead of RUN.
//  - RUN: prescaler increments each cycle; at TICK_DIV-1 it returns to 0 and a tick is applied:
//    sec_units 9..0, at 0 wraps to 9 with borrow; sec_tens 5..0 wraps to 5; min_units 9..0 wraps to 9;
//    min_tens 9..0. sec_tick=1 on the same cycle bcd_out changes (registered, both visible together).
//  - If the tick yields 0000: next state DONE; first tick latency after start = TICK_DIV cycles.
//  - pause=1 in RUN: go to PAUSE, prescaler holds value, no tick. pause=0 in PAUSE: back to RUN,
//    prescaler resumes from held value. pause ignored in IDLE and DONE.
//  - DONE: done=1 for exactly one cycle, bcd_out=0000, then IDLE. busy=running=0 in DONE.
//  - abort: next state IDLE, bcd_out:=0000, prescaler:=0, done never asserted. abort in IDLE harmless.
//  - start and abort same cycle: abort wins. start while pause=1: loads, enters RUN, PAUSE next cycle.
//  - Min tens never underflows: 0000 is detected before any wrap of min_tens.
// CONFIGURATION
//  TIMER_AUTO_RELOAD_EN defined: last loaded (clamped) duration is stored; in DONE, done pulses and
//   the stored duration is reloaded, prescaler:=0, next state RUN (cyclic watering). abort still
//   returns to IDLE. A stored duration of 0000 does not reload; goes to IDLE.
//  Not defined: DONE always proceeds to IDLE; no duration storage register is built.
// TESTING  (TICK_DIV=4)
//  - reset then idle 10 cycles -> bcd_out=0000, all flags 0.
//  - start, load_bcd=16'h0012 -> bcd_out 0012, 0011 after 4 cycles, ... 0000 at tick 12, done 1 cycle.
//  - load 16'h0100 -> first tick gives 0059; load 16'h1000 -> first tick gives 0959.
//  - load 16'hFF7C -> bcd_out=9959 (clamped); load 0000 -> done next cycle, no sec_tick.
//  - run 0005, pause=1 for 20 cycles mid-count -> bcd_out frozen, busy=1, running=0; resumes exact.
//  - abort mid-count and abort+start same cycle -> IDLE, bcd_out=0000, done never pulses;
//    with TIMER_AUTO_RELOAD_EN, 0002 -> done pulse then 0002 reloaded and count repeats.

Source files
------------

// File: rtl/timer_cascade_sequencer.sv
// Irrigation countdown sequencer: loads a clamped BCD MM:SS duration and decrements it once per TICK_DIV clocks.
// Optional build macro TIMER_AUTO_RELOAD_EN reloads the last started duration on completion (cyclic watering).
module timer_cascade_sequencer #(
   parameter int unsigned TICK_DIV = 50_000_000,
   parameter int unsigned CNT_W    = 26
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        pause,
   input  logic        abort,
   input  logic [15:0] load_bcd,
   output logic [15:0] bcd_out,
   output logic        running,
   output logic        busy,
   output logic        sec_tick,
   output logic        done
);

   localparam int unsigned BCD_W = 16;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

   state_t             state;
   logic [CNT_W-1:0]   presc;
   logic [BCD_W-1:0]   load_c;
   logic [BCD_W-1:0]   dec_c;
   logic               tick_due_c;

   // Saturate each digit to its legal BCD range; seconds tens stops at 5.
   function automatic logic [BCD_W-1:0] clamp_bcd(input logic [BCD_W-1:0] v);
      logic [BCD_W-1:0] r;
      r[15:12] = (v[15:12] > 4'd9) ? 4'd9 : v[15:12];
      r[11:8]  = (v[11:8]  > 4'd9) ? 4'd9 : v[11:8];
      r[7:4]   = (v[7:4]   > 4'd5) ? 4'd5 : v[7:4];
      r[3:0]   = (v[3:0]   > 4'd9) ? 4'd9 : v[3:0];
      return r;
   endfunction

   // One-second decrement with borrow through the digit cascade.
   function automatic logic [BCD_W-1:0] dec_bcd(input logic [BCD_W-1:0] v);
      logic [BCD_W-1:0] r;
      r = v;
      if (v[3:0] != 4'd0) begin
         r[3:0] = v[3:0] - 4'd1;
      end else begin
         r[3:0] = 4'd9;
         if (v[7:4] != 4'd0) begin
            r[7:4] = v[7:4] - 4'd1;
         end else begin
            r[7:4] = 4'd5;
            if (v[11:8] != 4'd0) begin
               r[11:8] = v[11:8] - 4'd1;
            end else begin
               r[11:8]  = 4'd9;
               r[15:12] = v[15:12] - 4'd1;
            end
         end
      end
      return r;
   endfunction

   always_comb begin
      load_c     = clamp_bcd(load_bcd);
      dec_c      = dec_bcd(bcd_out);
      tick_due_c = (presc == CNT_W'(TICK_DIV - 1));
   end

`ifdef TIMER_AUTO_RELOAD_EN
   logic [BCD_W-1:0] reload_q;

   // Remember the most recent accepted duration for cyclic reload.
   always_ff @(posedge clk) begin
      if (reset) begin
         reload_q <= '0;
      end else if (start && !abort) begin
         reload_q <= load_c;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= S_IDLE;
         presc    <= '0;
         bcd_out  <= '0;
         running  <= 1'b0;
         busy     <= 1'b0;
         sec_tick <= 1'b0;
         done     <= 1'b0;
      end else begin
         sec_tick <= 1'b0;
         done     <= 1'b0;
         if (abort) begin
            state   <= S_IDLE;
            presc   <= '0;
            bcd_out <= '0;
            running <= 1'b0;
            busy    <= 1'b0;
         end else if (start) begin
            presc   <= '0;
            bcd_out <= load_c;
            if (load_c == '0) begin
               state   <= S_DONE;
               done    <= 1'b1;
               running <= 1'b0;
               busy    <= 1'b0;
            end else begin
               state   <= S_RUN;
               running <= 1'b1;
               busy    <= 1'b1;
            end
         end else begin
            case (state)
               S_IDLE: begin
                  state <= S_IDLE;
               end
               S_RUN: begin
                  if (pause) begin
                     state   <= S_PAUSE;
                     running <= 1'b0;
                  end else if (tick_due_c) begin
                     presc    <= '0;
                     bcd_out  <= dec_c;
                     sec_tick <= 1'b1;
                     if (dec_c == '0) begin
                        state   <= S_DONE;
                        done    <= 1'b1;
                        running <= 1'b0;
                        busy    <= 1'b0;
                     end
                  end else begin
                     presc <= presc + CNT_W'(1);
                  end
               end
               S_PAUSE: begin
                  if (!pause) begin
                     state   <= S_RUN;
                     running <= 1'b1;
                  end
               end
               S_DONE: begin
`ifdef TIMER_AUTO_RELOAD_EN
                  if (reload_q != '0) begin
                     state   <= S_RUN;
                     presc   <= '0;
                     bcd_out <= reload_q;
                     running <= 1'b1;
                     busy    <= 1'b1;
                  end else begin
                     state <= S_IDLE;
                  end
`else
                  state <= S_IDLE;
`endif
               end
               default: begin
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_timer_cascade_sequencer.sv
// Cycle-by-cycle vector bench for timer_cascade_sequencer with TICK_DIV=4.
// Expectations follow TIMER_AUTO_RELOAD_EN when it is defined for the build.
module tb_timer_cascade_sequencer;

   localparam int unsigned TICK_DIV = 4;
   localparam int unsigned CNT_W    = 3;

   logic        clk = 1'b0;
   logic        reset, start, pause, abort;
   logic [15:0] load_bcd;
   logic [15:0] bcd_out;
   logic        running, busy, sec_tick, done;

   always #5 clk = ~clk;

   timer_cascade_sequencer #(.TICK_DIV(TICK_DIV), .CNT_W(CNT_W)) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .pause    (pause),
      .abort    (abort),
      .load_bcd (load_bcd),
      .bcd_out  (bcd_out),
      .running  (running),
      .busy     (busy),
      .sec_tick (sec_tick),
      .done     (done)
   );

   typedef struct {
      logic        rst, st, pa, ab;
      logic [15:0] ld;
      logic [15:0] e_bcd;
      logic        e_run, e_busy, e_tick, e_done;
   } vec_t;

   vec_t vecs[$];
   int   n_vec  = 0;
   int   n_err  = 0;
   int   n_wait = 0;

   // Total seconds to packed MM:SS BCD.
   function automatic logic [15:0] to_bcd(input int secs);
      int m, s;
      m = secs / 60;
      s = secs % 60;
      return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
   endfunction

   task automatic push(input logic rst, input logic st, input logic pa, input logic ab,
                       input logic [15:0] ld, input logic [15:0] e_bcd,
                       input logic e_run, input logic e_busy, input logic e_tick, input logic e_done);
      vec_t v;
      v.rst = rst; v.st = st; v.pa = pa; v.ab = ab; v.ld = ld;
      v.e_bcd = e_bcd; v.e_run = e_run; v.e_busy = e_busy; v.e_tick = e_tick; v.e_done = e_done;
      vecs.push_back(v);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) push(0, 0, 0, 0, 16'h0, 16'h0000, 0, 0, 0, 0);
   endtask

   task automatic run_hold(input int n, input logic [15:0] b);
      for (int i = 0; i < n; i++) push(0, 0, 0, 0, 16'h0, b, 1, 1, 0, 0);
   endtask

   task automatic do_abort();
      push(0, 0, 0, 1, 16'h0, 16'h0000, 0, 0, 0, 0);
   endtask

   // n ticks starting from 'from' seconds, prescaler freshly at 0.
   task automatic countdown(input int from, input int n);
      for (int k = 1; k <= n; k++) begin
         run_hold(TICK_DIV - 1, to_bcd(from - k + 1));
         if (from - k == 0) push(0, 0, 0, 0, 16'h0, 16'h0000, 0, 0, 1, 1);
         else               push(0, 0, 0, 0, 16'h0, to_bcd(from - k), 1, 1, 1, 0);
      end
   endtask

   task automatic after_done(input logic [15:0] reload);
`ifdef TIMER_AUTO_RELOAD_EN
      push(0, 0, 0, 0, 16'h0, reload, 1, 1, 0, 0);
      do_abort();
`else
      if (reload == 16'h0) idle(1);
      else idle(1);
`endif
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0; load_bcd = 16'h0;

      // reset and quiet idle
      push(1, 0, 0, 0, 16'h0, 16'h0000, 0, 0, 0, 0);
      push(1, 0, 0, 0, 16'h0, 16'h0000, 0, 0, 0, 0);
      idle(10);
      // full 12 s countdown
      push(0, 1, 0, 0, 16'h0012, 16'h0012, 1, 1, 0, 0);
      countdown(12, 12);
      after_done(16'h0012);
      // minute and ten-minute borrows
      push(0, 1, 0, 0, 16'h0100, 16'h0100, 1, 1, 0, 0);
      countdown(60, 1);
      do_abort();
      push(0, 1, 0, 0, 16'h1000, 16'h1000, 1, 1, 0, 0);
      countdown(600, 1);
      do_abort();
      // clamping, then abort beats start
      push(0, 1, 0, 0, 16'hFF7C, 16'h9959, 1, 1, 0, 0);
      run_hold(1, 16'h9959);
      push(0, 1, 0, 1, 16'h0012, 16'h0000, 0, 0, 0, 0);
      idle(2);
      // zero load goes straight to done
      push(0, 1, 0, 0, 16'h0000, 16'h0000, 0, 0, 0, 1);
      idle(2);
      do_abort();
      // pause mid-count for 20 cycles
      push(0, 1, 0, 0, 16'h0005, 16'h0005, 1, 1, 0, 0);
      countdown(5, 1);
      run_hold(1, 16'h0004);
      for (int i = 0; i < 20; i++) push(0, 0, 1, 0, 16'h0, 16'h0004, 0, 1, 0, 0);
      push(0, 0, 0, 0, 16'h0, 16'h0004, 1, 1, 0, 0);
      run_hold(TICK_DIV - 2, 16'h0004);
      push(0, 0, 0, 0, 16'h0, 16'h0003, 1, 1, 1, 0);
      countdown(3, 3);
      after_done(16'h0005);
      // abort mid-count, done never pulses
      push(0, 1, 0, 0, 16'h0012, 16'h0012, 1, 1, 0, 0);
      run_hold(2, 16'h0012);
      do_abort();
      idle(5);
      // start while pause held
      push(0, 1, 1, 0, 16'h0003, 16'h0003, 1, 1, 0, 0);
      for (int i = 0; i < 3; i++) push(0, 0, 1, 0, 16'h0, 16'h0003, 0, 1, 0, 0);
      push(0, 0, 0, 0, 16'h0, 16'h0003, 1, 1, 0, 0);
      countdown(3, 3);
      after_done(16'h0003);
      // synchronous reset mid-run
      push(0, 1, 0, 0, 16'h0005, 16'h0005, 1, 1, 0, 0);
      run_hold(2, 16'h0005);
      push(1, 0, 0, 0, 16'h0, 16'h0000, 0, 0, 0, 0);
      idle(2);
`ifdef TIMER_AUTO_RELOAD_EN
      // cyclic reload of 0002
      push(0, 1, 0, 0, 16'h0002, 16'h0002, 1, 1, 0, 0);
      countdown(2, 2);
      push(0, 0, 0, 0, 16'h0, 16'h0002, 1, 1, 0, 0);
      countdown(2, 2);
      after_done(16'h0002);
`endif

      foreach (vecs[i]) begin
         reset    = vecs[i].rst;
         start    = vecs[i].st;
         pause    = vecs[i].pa;
         abort    = vecs[i].ab;
         load_bcd = vecs[i].ld;
         @(posedge clk);
         #1;
         n_vec++;
         if ({bcd_out, running, busy, sec_tick, done} !==
             {vecs[i].e_bcd, vecs[i].e_run, vecs[i].e_busy, vecs[i].e_tick, vecs[i].e_done}) begin
            n_err++;
            $display("FAIL vec %0d: got bcd=%h run=%b busy=%b tick=%b done=%b, expected bcd=%h run=%b busy=%b tick=%b done=%b",
                     i, bcd_out, running, busy, sec_tick, done,
                     vecs[i].e_bcd, vecs[i].e_run, vecs[i].e_busy, vecs[i].e_tick, vecs[i].e_done);
         end
      end

      // directed reset-state check
      reset = 1'b1; start = 1'b0; pause = 1'b0; abort = 1'b0; load_bcd = 16'h0;
      repeat (2) @(posedge clk);
      #1;
      if (bcd_out !== 16'h0000 || running !== 1'b0 || busy !== 1'b0 ||
          sec_tick !== 1'b0 || done !== 1'b0) begin
         n_err++;
         $display("FAIL reset state: bcd=%h run=%b busy=%b tick=%b done=%b",
                  bcd_out, running, busy, sec_tick, done);
      end
      reset = 1'b0;

      // directed bounded wait for done
      load_bcd = 16'h0003;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
      load_bcd = 16'h0;
      if (bcd_out !== 16'h0003 || running !== 1'b1 || busy !== 1'b1) begin
         n_err++;
         $display("FAIL load: bcd=%h run=%b busy=%b", bcd_out, running, busy);
      end
      n_wait = 0;
      while (done !== 1'b1 && n_wait < int'(3 * TICK_DIV + 8)) begin
         @(posedge clk);
         #1;
         n_wait++;
      end
      if (done !== 1'b1) begin
         n_err++;
         $display("FAIL wait expired: done not seen within %0d cycles", n_wait);
      end else begin
         if (n_wait != int'(3 * TICK_DIV)) begin
            n_err++;
            $display("FAIL done latency: %0d cycles, expected %0d", n_wait, 3 * TICK_DIV);
         end
         if (bcd_out !== 16'h0000 || sec_tick !== 1'b1) begin
            n_err++;
            $display("FAIL done cycle: bcd=%h tick=%b", bcd_out, sec_tick);
         end
         @(posedge clk);
         #1;
         if (done !== 1'b0) begin
            n_err++;
            $display("FAIL done pulse longer than one cycle");
         end
      end
      abort = 1'b1;
      @(posedge clk);
      #1;
      abort = 1'b0;
      if (bcd_out !== 16'h0000 || running !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
         n_err++;
         $display("FAIL abort: bcd=%h run=%b busy=%b done=%b", bcd_out, running, busy, done);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      if (n_err == 0) $display("PASS");
      else            $display("FAIL: %0d errors", n_err);
      $finish;
   end

endmodule
